// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: a circular buffer between fetch and pre-decode.
// Accepts up to two instructions per cycle and presents the two oldest
// entries show-ahead. Each entry carries its branch-prediction sideband.

// Per-slot output gate: forces a head slot to zero when it holds no entry.
module ifq_out_slot #(
  parameter int W = 8
) (
  input  logic         vld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  assign q = vld ? d : '0;
endmodule

module inst_fetch_queue #(
  parameter int DEPTH           = 8,
  parameter int INST_WIDTH      = 32,
  parameter int INST_ADDR_WIDTH = 32,
  parameter int BP_GHR_BITS     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       stall,
  input  logic [INST_WIDTH-1:0]      in_inst_0,
  input  logic [INST_WIDTH-1:0]      in_inst_1,
  input  logic [INST_ADDR_WIDTH-1:0] in_pc_0,
  input  logic [INST_ADDR_WIDTH-1:0] in_pc_1,
  input  logic [1:0]                 in_inst_valid,
  input  logic                       in_pred_taken_0,
  input  logic                       in_pred_taken_1,
  input  logic [INST_ADDR_WIDTH-1:0] in_pred_target_0,
  input  logic [INST_ADDR_WIDTH-1:0] in_pred_target_1,
  input  logic [BP_GHR_BITS-1:0]     in_pred_hist_0,
  input  logic [BP_GHR_BITS-1:0]     in_pred_hist_1,
  output logic                       in_ready,
  output logic [INST_WIDTH-1:0]      out_inst_0,
  output logic [INST_WIDTH-1:0]      out_inst_1,
  output logic [INST_ADDR_WIDTH-1:0] out_pc_0,
  output logic [INST_ADDR_WIDTH-1:0] out_pc_1,
  output logic                       out_pred_taken_0,
  output logic                       out_pred_taken_1,
  output logic [INST_ADDR_WIDTH-1:0] out_pred_target_0,
  output logic [INST_ADDR_WIDTH-1:0] out_pred_target_1,
  output logic [BP_GHR_BITS-1:0]     out_pred_hist_0,
  output logic [BP_GHR_BITS-1:0]     out_pred_hist_1,
  output logic [1:0]                 out_inst_valid,
  output logic [$clog2(DEPTH):0]     out_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [INST_WIDTH-1:0]      inst;
    logic [INST_ADDR_WIDTH-1:0] pc;
    logic                       taken;
    logic [INST_ADDR_WIDTH-1:0] target;
    logic [BP_GHR_BITS-1:0]     hist;
  } entry_t;

  localparam int EW = $bits(entry_t);

  entry_t        mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;

  entry_t        in_e0, in_e1, wr_first;
  logic          push_en;
  logic [1:0]    push_n, pop_n;

  assign in_e0 = '{in_inst_0, in_pc_0, in_pred_taken_0, in_pred_target_0, in_pred_hist_0};
  assign in_e1 = '{in_inst_1, in_pc_1, in_pred_taken_1, in_pred_target_1, in_pred_hist_1};

  // Room for a full batch, judged on registered occupancy only.
  assign in_ready = (count <= CW'(DEPTH - 2));
  assign push_en  = in_ready && (in_inst_valid != 2'b00);
  assign push_n   = push_en ? ({1'b0, in_inst_valid[0]} + {1'b0, in_inst_valid[1]}) : 2'd0;
  // Compaction: the lone valid slot (or slot 0 of a pair) lands at tail.
  assign wr_first = in_inst_valid[0] ? in_e0 : in_e1;

  assign out_inst_valid = (count >= CW'(2)) ? 2'b11 :
                          (count == CW'(1)) ? 2'b01 : 2'b00;
  assign pop_n = stall ? 2'd0 : ({1'b0, out_inst_valid[0]} + {1'b0, out_inst_valid[1]});
  assign out_count = count;

  // Pointer and occupancy update; reset beats flush beats push/pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop_n);
      tail  <= tail + PW'(push_n);
      count <= count + CW'(push_n) - CW'(pop_n);
    end
  end

  // Entry storage; never cleared, only written by accepted pushes.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push_en) begin
      mem[tail] <= wr_first;
      if (in_inst_valid == 2'b11) mem[tail + PW'(1)] <= in_e1;
    end
  end

  // Show-ahead head read, masked per slot.
  logic [1:0][EW-1:0] rd_raw, rd_msk;
  assign rd_raw[0] = mem[head];
  assign rd_raw[1] = mem[head + PW'(1)];

  for (genvar s = 0; s < 2; s++) begin : g_slot
    ifq_out_slot #(.W(EW)) u_slot (
      .vld (out_inst_valid[s]),
      .d   (rd_raw[s]),
      .q   (rd_msk[s])
    );
  end

  entry_t o0, o1;
  assign o0 = entry_t'(rd_msk[0]);
  assign o1 = entry_t'(rd_msk[1]);

  assign out_inst_0        = o0.inst;
  assign out_inst_1        = o1.inst;
  assign out_pc_0          = o0.pc;
  assign out_pc_1          = o1.pc;
  assign out_pred_taken_0  = o0.taken;
  assign out_pred_taken_1  = o1.taken;
  assign out_pred_target_0 = o0.target;
  assign out_pred_target_1 = o1.target;
  assign out_pred_hist_0   = o0.hist;
  assign out_pred_hist_1   = o1.hist;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed scenarios then random traffic, all
// compared against a queue-based reference of the fetch queue.
module tb_inst_fetch_queue;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        tk;
    logic [31:0] tg;
    logic [7:0]  h;
  } ent_t;

  logic clk = 1'b0;
  logic rst, flush, stall;
  logic [31:0] in_inst_0, in_inst_1, in_pc_0, in_pc_1, in_tg_0, in_tg_1;
  logic in_tk_0, in_tk_1;
  logic [7:0] in_h_0, in_h_1;
  logic [1:0] in_v;
  logic in_ready;
  logic [31:0] out_inst_0, out_inst_1, out_pc_0, out_pc_1, out_tg_0, out_tg_1;
  logic out_tk_0, out_tk_1;
  logic [7:0] out_h_0, out_h_1;
  logic [1:0] out_v;
  logic [3:0] out_count;

  int n_chk = 0;
  int n_err = 0;
  ent_t q[$];
  ent_t z = '0;

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .in_inst_0(in_inst_0), .in_inst_1(in_inst_1),
    .in_pc_0(in_pc_0), .in_pc_1(in_pc_1),
    .in_inst_valid(in_v),
    .in_pred_taken_0(in_tk_0), .in_pred_taken_1(in_tk_1),
    .in_pred_target_0(in_tg_0), .in_pred_target_1(in_tg_1),
    .in_pred_hist_0(in_h_0), .in_pred_hist_1(in_h_1),
    .in_ready(in_ready),
    .out_inst_0(out_inst_0), .out_inst_1(out_inst_1),
    .out_pc_0(out_pc_0), .out_pc_1(out_pc_1),
    .out_pred_taken_0(out_tk_0), .out_pred_taken_1(out_tk_1),
    .out_pred_target_0(out_tg_0), .out_pred_target_1(out_tg_1),
    .out_pred_hist_0(out_h_0), .out_pred_hist_1(out_h_1),
    .out_inst_valid(out_v), .out_count(out_count)
  );

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t mk(logic [31:0] pc);
    ent_t e;
    e.inst = pc ^ 32'hdead_0000;
    e.pc   = pc;
    e.tk   = pc[2];
    e.tg   = pc + 32'h40;
    e.h    = pc[7:0] ^ 8'h5a;
    return e;
  endfunction

  function automatic ent_t rnd();
    ent_t e;
    e.inst = $urandom; e.pc = $urandom; e.tk = 1'($urandom);
    e.tg = $urandom; e.h = 8'($urandom);
    return e;
  endfunction

  // Compare every observable output against the reference queue contents.
  task automatic check_all();
    ent_t e0, e1;
    int sz = q.size();
    e0 = (sz >= 1) ? q[0] : z;
    e1 = (sz >= 2) ? q[1] : z;
    chk("count",   64'(out_count), 64'(sz));
    chk("ready",   64'(in_ready),  64'((DEPTH - sz) >= 2));
    chk("valid",   64'(out_v),     64'((sz >= 2) ? 2'b11 : (sz == 1) ? 2'b01 : 2'b00));
    chk("slot0",   {out_inst_0, out_pc_0}, {e0.inst, e0.pc});
    chk("slot0sb", {23'd0, out_tk_0, out_tg_0, out_h_0}, {23'd0, e0.tk, e0.tg, e0.h});
    chk("slot1",   {out_inst_1, out_pc_1}, {e1.inst, e1.pc});
    chk("slot1sb", {23'd0, out_tk_1, out_tg_1, out_h_1}, {23'd0, e1.tk, e1.tg, e1.h});
  endtask

  // One clock: drive at negedge, advance the reference at posedge, check after.
  task automatic step(logic r, logic f, logic s, logic [1:0] v, ent_t a, ent_t b);
    bit rdy;
    int npop;
    @(negedge clk);
    rst = r; flush = f; stall = s; in_v = v;
    in_inst_0 = a.inst; in_pc_0 = a.pc; in_tk_0 = a.tk; in_tg_0 = a.tg; in_h_0 = a.h;
    in_inst_1 = b.inst; in_pc_1 = b.pc; in_tk_1 = b.tk; in_tg_1 = b.tg; in_h_1 = b.h;
    @(posedge clk);
    if (r || f) q.delete();
    else begin
      rdy  = (DEPTH - q.size()) >= 2;
      npop = s ? 0 : ((q.size() >= 2) ? 2 : q.size());
      repeat (npop) void'(q.pop_front());
      if (rdy && v[0]) q.push_back(a);
      if (rdy && v[1]) q.push_back(b);
    end
    #1;
    check_all();
  endtask

  initial begin
    // Reset
    step(1, 0, 0, 2'b00, z, z);
    step(1, 0, 0, 2'b11, mk(32'h10), mk(32'h14));
    chk("rst_count", 64'(out_count), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_valid", 64'(out_v), 64'd0);

    // Single batch through an idle queue
    step(0, 0, 0, 2'b11, mk(32'h100), mk(32'h104));
    chk("b1_valid", 64'(out_v), 64'd3);
    chk("b1_pc0", 64'(out_pc_0), 64'h100);
    chk("b1_pc1", 64'(out_pc_1), 64'h104);
    step(0, 0, 0, 2'b00, z, z);
    chk("b1_empty", 64'(out_v), 64'd0);

    // Fill under stall
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 2'b11, mk(32'h300 + 16 * i), mk(32'h308 + 16 * i));
      if (i == 2) begin
        chk("fill3_count", 64'(out_count), 64'd6);
        chk("fill3_ready", 64'(in_ready), 64'd1);
      end
      if (i >= 3) begin
        chk("fill_count", 64'(out_count), 64'd8);
        chk("fill_ready", 64'(in_ready), 64'd0);
        chk("fill_head", 64'(out_pc_0), 64'h300);
      end
    end
    step(0, 1, 1, 2'b00, z, z);

    // Single-slot pushes compact
    step(0, 0, 1, 2'b10, z, mk(32'h204));
    step(0, 0, 1, 2'b01, mk(32'h208), z);
    chk("cmp_count", 64'(out_count), 64'd2);
    chk("cmp_pc0", 64'(out_pc_0), 64'h204);
    chk("cmp_pc1", 64'(out_pc_1), 64'h208);
    chk("cmp_valid", 64'(out_v), 64'd3);

    // Reach 7, then blocked push with pop, then push+pop across the wrap
    step(0, 0, 1, 2'b11, mk(32'h400), mk(32'h404));
    step(0, 0, 1, 2'b11, mk(32'h408), mk(32'h40c));
    step(0, 0, 1, 2'b01, mk(32'h410), z);
    chk("c7_count", 64'(out_count), 64'd7);
    chk("c7_ready", 64'(in_ready), 64'd0);
    step(0, 0, 0, 2'b11, mk(32'h500), mk(32'h504));
    chk("blk_count", 64'(out_count), 64'd5);
    chk("blk_pc0", 64'(out_pc_0), 64'h400);
    step(0, 0, 0, 2'b11, mk(32'h600), mk(32'h604));
    chk("wrap_count", 64'(out_count), 64'd5);
    chk("wrap_pc0", 64'(out_pc_0), 64'h408);
    repeat (2) step(0, 0, 0, 2'b00, z, z);
    chk("wrap_tail", 64'(out_pc_0), 64'h604);
    step(0, 0, 0, 2'b00, z, z);

    // Flush beats a coincident push
    step(0, 0, 1, 2'b11, mk(32'h700), mk(32'h704));
    step(0, 0, 1, 2'b11, mk(32'h708), mk(32'h70c));
    step(0, 0, 1, 2'b01, mk(32'h710), z);
    step(0, 1, 0, 2'b11, mk(32'h800), mk(32'h804));
    chk("fl_count", 64'(out_count), 64'd0);
    chk("fl_valid", 64'(out_v), 64'd0);
    chk("fl_ready", 64'(in_ready), 64'd1);

    // Reset mid-operation
    step(0, 0, 1, 2'b11, mk(32'h900), mk(32'h904));
    step(0, 0, 1, 2'b11, mk(32'h908), mk(32'h90c));
    step(0, 0, 1, 2'b01, mk(32'h910), z);
    step(1, 0, 0, 2'b11, mk(32'ha00), mk(32'ha04));
    chk("mr_count", 64'(out_count), 64'd0);
    chk("mr_valid", 64'(out_v), 64'd0);
    chk("mr_ready", 64'(in_ready), 64'd1);
    chk("mr_pc0", 64'(out_pc_0), 64'd0);

    // Single entry presents on slot 0 only
    step(0, 0, 1, 2'b01, mk(32'hb00), z);
    chk("one_valid", 64'(out_v), 64'd1);
    chk("one_pc1", 64'(out_pc_1), 64'd0);
    chk("one_inst1", 64'(out_inst_1), 64'd0);
    step(0, 0, 0, 2'b00, z, z);
    chk("one_drain", 64'(out_count), 64'd0);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 2) == 0), 2'($urandom), rnd(), rnd());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the number of queue entries; legal values are powers of two >= 4.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port flush  input  1  discards all queued entries.
REQ-005 SHALL have port stall  input  1  downstream (pre-decode) cannot accept this cycle.
REQ-006 SHALL have ports in_inst_0/in_inst_1  input  INST_WIDTH each  fetched instructions, slot 0 older.
REQ-007 SHALL have ports in_pc_0/in_pc_1  input  INST_ADDR_WIDTH each  instruction PCs.
REQ-008 SHALL have port in_inst_valid  input  IF_BATCH_SIZE (2)  per-slot valid.
REQ-009 SHALL have ports in_pred_taken_0/1 (1), in_pred_target_0/1 (INST_ADDR_WIDTH), in_pred_hist_0/1 (BP_GHR_BITS)  input  branch-prediction sideband per slot.
REQ-010 SHALL have port in_ready  output  1  queue can accept a full batch this cycle.
REQ-011 SHALL have ports out_inst_0/1, out_pc_0/1, out_pred_taken_0/1, out_pred_target_0/1, out_pred_hist_0/1  output  same widths as inputs  head entries, slot 0 oldest.
REQ-012 SHALL have port out_inst_valid  output  2  per-slot valid of head entries.
REQ-013 SHALL have port out_count  output  clog2(DEPTH)+1  current occupancy.

Function
REQ-014 SHALL store per entry: inst, pc, pred_taken, pred_target, pred_hist.
REQ-015 SHALL drive in_ready = 1 when (DEPTH - out_count) >= 2, computed from registered occupancy only (no same-cycle pop credit).
REQ-016 SHALL push when in_ready=1 and in_inst_valid != 0; inputs with in_ready=0 are ignored (fetch holds them).
REQ-017 SHALL compact on push: valid=11 writes slot0 then slot1 at tail, tail+1; valid=01 writes slot0 at tail; valid=10 writes slot1 at tail; push count = popcount(in_inst_valid).
REQ-018 SHALL present head combinationally (show-ahead): out_inst_valid = 11 if count>=2, 01 if count==1, 00 if count==0.
REQ-019 SHALL drive out_* slot fields to zero when the corresponding out_inst_valid bit is 0.
REQ-020 SHALL pop popcount(out_inst_valid) entries at the clock edge when stall=0; no pop when stall=1 (head held stable).
REQ-021 SHALL update occupancy as count + pushed - popped when push and pop coincide; never exceed DEPTH, never go below 0.
REQ-022 SHALL wrap head and tail pointers modulo DEPTH; a batch straddling index DEPTH-1 -> 0 is written/read in order.
REQ-023 SHALL give flush priority over push and pop: on flush, head=tail=0, count=0, in-cycle inputs dropped; in_ready=1 next cycle.
REQ-024 SHALL treat in_inst_valid=00 with in_ready=1 as no push.
REQ-025 SHALL have one-cycle latency from push edge to entry visible on out_* (empty queue, stall=0).
REQ-026 SHALL preserve program order: an instruction at slot 0 of any output cycle is older than slot 1 and all later outputs.

Reset
REQ-027 SHALL, when rst=1 at a clock edge, set head=tail=0, count=0, regardless of flush/stall/inputs; rst has priority over flush.
REQ-028 SHALL present after reset: out_inst_valid=00, all out_* data 0, out_count=0, in_ready=1.
REQ-029 SHALL tolerate reset asserted mid-operation (non-empty queue) with identical post-reset state; entry storage need not be cleared.

Verification
REQ-030 Bench SHALL cover: reset, push valid=11 (pc 0x100,0x104), stall=0 -> next cycle out_inst_valid=11, out_pc_0=0x100, out_pc_1=0x104; following cycle empty, out_inst_valid=00.
REQ-031 Bench SHALL cover: stall=1, push batches of 11 each cycle (DEPTH=8) -> after 3 pushes count=6, in_ready=1; after 4 count=8, in_ready=0; 5th batch ignored, count stays 8.
REQ-032 Bench SHALL cover: push valid=10 (pc 0x204) then valid=01 (pc 0x208) with stall=1 -> count=2, out_pc_0=0x204, out_pc_1=0x208, out_inst_valid=11.
REQ-033 Bench SHALL cover: count=7, stall=0, push 11 -> in_ready=0 blocks push, pop 2 -> count=5; next cycle push 11 + pop 2 -> count=5, order preserved across pointer wrap.
REQ-034 Bench SHALL cover: count=5 with simultaneous flush=1 and push 11 -> next cycle count=0, out_inst_valid=00, in_ready=1; rst=1 with flush=0 gives same state.
REQ-035 Bench SHALL cover: count=1, stall=0 -> out_inst_valid=01, slot 1 fields all 0; after edge count=0.
